// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and counter widths for the two-port BRAM arbiter.
package mem_port_arbiter_pkg;

  localparam int STARVE_W = 4;
  localparam int LAT_W    = 3;

  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_RESP} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Combinational grant decision between the fetch port and the load/store port.
module arb_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3
)(
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  input  logic                can_accept,
  output arb_owner_t          grant
);

  // D wins conflicts until IF has been passed over STARVE_MAX times in a row.
  always_comb begin
    grant = OWN_NONE;
    if (can_accept) begin
      if (d_req && (!if_req || starve_cnt != STARVE_W'(STARVE_MAX))) begin
        grant = OWN_D;
      end else if (if_req) begin
        grant = OWN_IF;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous BRAM between the fetch (IF) and load/store (D) ports,
// with one transaction in flight at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 3
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_req,
  input  logic [ADDR_W-1:0]            if_addr,
  output logic                         if_ready,
  output logic                         if_rvalid,
  output logic [31:0]                  if_rdata,
  output logic                         if_err,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [3:0]                   d_wstrb,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [31:0]                  d_wdata,
  output logic                         d_ready,
  output logic                         d_rvalid,
  output logic [31:0]                  d_rdata,
  output logic                         d_err,
  output logic                         mem_en,
  output logic [3:0]                   mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_rdata
);

  localparam int                MA_W       = $clog2(MEM_WORDS);
  localparam logic [LAT_W-1:0]  LAT_LOAD   = LAT_W'(MEM_LATENCY - 1);
  localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(MEM_WORDS);

  arb_state_t          r_state, w_stateNext;
  arb_owner_t          r_owner, w_grant;
  logic [STARVE_W-1:0] r_starveCnt;
  logic [LAT_W-1:0]    r_latCnt;
  logic                r_err, r_isStore;
  logic                w_canAccept, w_resp;
  logic [ADDR_W-3:0]   w_ifWord, w_dWord, w_selWord;
  logic                w_ifErr, w_dErr, w_selErr;
  logic                w_unused;

  assign w_unused    = &{1'b0, if_addr[1:0], d_addr[1:0]};
  assign w_ifWord    = if_addr[ADDR_W-1:2];
  assign w_dWord     = d_addr[ADDR_W-1:2];
  assign w_ifErr     = (w_ifWord >= WORD_LIMIT);
  assign w_dErr      = (w_dWord >= WORD_LIMIT);
  assign w_selWord   = (w_grant == OWN_D) ? w_dWord : w_ifWord;
  assign w_selErr    = (w_grant == OWN_D) ? w_dErr : w_ifErr;
  assign w_canAccept = !rst && (r_state == ARB_IDLE || r_state == ARB_RESP);
  assign w_resp      = !rst && (r_state == ARB_RESP);

  arb_select #(.STARVE_MAX(STARVE_MAX)) u_arbSelect (
    .if_req     (if_req),
    .d_req      (d_req),
    .starve_cnt (r_starveCnt),
    .can_accept (w_canAccept),
    .grant      (w_grant)
  );

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ARB_IDLE, ARB_RESP: w_stateNext = (w_grant != OWN_NONE) ? ARB_WAIT : ARB_IDLE;
      ARB_WAIT:           if (r_latCnt == '0) w_stateNext = ARB_RESP;
      default:            w_stateNext = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_NONE;
      r_starveCnt <= '0;
      r_latCnt    <= '0;
      r_err       <= 1'b0;
      r_isStore   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_grant != OWN_NONE) begin
        r_owner   <= w_grant;
        r_err     <= w_selErr;
        r_isStore <= (w_grant == OWN_D) && d_we;
        r_latCnt  <= LAT_LOAD;
      end else if (r_state == ARB_WAIT && r_latCnt != '0) begin
        r_latCnt <= r_latCnt - LAT_W'(1);
      end else if (r_state == ARB_RESP) begin
        r_owner <= OWN_NONE;
      end
      // The counter only grows while IF is actually being passed over.
      if (w_grant == OWN_IF) begin
        r_starveCnt <= '0;
      end else if (w_grant == OWN_D && if_req && r_starveCnt != STARVE_W'(STARVE_MAX)) begin
        r_starveCnt <= r_starveCnt + STARVE_W'(1);
      end
    end
  end

  // Memory strobes follow the grant in the acceptance cycle; out-of-range requests never reach the BRAM.
  always_comb begin
    if_ready  = (w_grant == OWN_IF);
    d_ready   = (w_grant == OWN_D);
    if_rvalid = w_resp && (r_owner == OWN_IF);
    d_rvalid  = w_resp && (r_owner == OWN_D);
    if_err    = if_rvalid && r_err;
    d_err     = d_rvalid && r_err;
    if_rdata  = (if_rvalid && !r_err) ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !r_err && !r_isStore) ? mem_rdata : '0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_grant != OWN_NONE && !w_selErr) begin
      mem_en   = 1'b1;
      mem_addr = w_selWord[MA_W-1:0];
      if (w_grant == OWN_D && d_we) begin
        mem_we    = d_wstrb;
        mem_wdata = d_wdata;
      end
    end
  end

endmodule
